// File: rtl/tlu_ch_tx_if.sv
// tlu_ch_tx_if: configuration, status and word bus of one TLU TX channel.
// CLK40 and RST stay outside as plain ports of the channel.
interface tlu_ch_tx_if;
  logic        EN;
  logic        EN_INVERT;
  logic        START;
  logic [15:0] DELAY;
  logic [15:0] WIDTH;
  logic [15:0] PERIOD;
  logic [7:0]  REPEAT;
  logic [11:0] TIME_STAMP;
  logic [15:0] OUT;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;
  logic [15:0] TX_RISING;

  modport master (
    output EN, EN_INVERT, START,
    output DELAY, WIDTH, PERIOD, REPEAT,
    output TIME_STAMP,
    input  OUT, BUSY, DONE, ERROR, TX_RISING
  );

  modport slave (
    input  EN, EN_INVERT, START,
    input  DELAY, WIDTH, PERIOD, REPEAT,
    input  TIME_STAMP,
    output OUT, BUSY, DONE, ERROR, TX_RISING
  );
endinterface

// File: rtl/tlu_ch_tx.sv
// tlu_ch_tx: fine-timed pulse train generator, one 16-bit
// serializer word per CLK40, bit 15 transmitted first.
module tlu_ch_tx #(
  parameter int CLKDV = 4
) (
  input logic        CLK40,
  input logic        RST,
  tlu_ch_tx_if.slave bus
);

  localparam int NB = CLKDV * 4;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nx;

  logic        st_v;
  logic [15:0] cfg_delay;
  logic [15:0] cfg_width;
  logic [15:0] cfg_period;
  logic [7:0]  cfg_repeat;

  logic [20:0] r;
  logic [20:0] f;
  logic [20:0] nr;
  logic        rpend;
  logic [7:0]  left;

  logic [NB-1:0] out_q;
  logic [15:0]   tx_q;
  logic          done_q;
  logic          err_q;

  logic          rej;
  logic          r_lt;
  logic          nr_ge;
  logic          cur_done;
  logic          has_next;
  logic          fin;
  logic [20:0]   nf;
  logic [20:0]   per16;
  logic [NB-1:0] pat;
  logic          rise_cur;
  logic          rise_nxt;
  logic          accept;
  logic          ld;
  logic          step;
  logic          done_nx;
  logic          err_nx;

  always_comb begin
    rej = (cfg_repeat == 8'd0) ||
          ((cfg_repeat > 8'd1) &&
           ({cfg_period, 4'd0} <= {4'd0, cfg_width}));
    per16    = {1'b0, cfg_period, 4'd0};
    r_lt     = r < 21'(NB);
    nr_ge    = !(nr < 21'(NB));
    cur_done = r_lt && (f <= 21'(NB));
    has_next = left > 8'd1;
    fin      = cur_done && !has_next;
    nf       = nr + {5'd0, cfg_width};
    rise_cur = rpend && r_lt && (cfg_width != 16'd0);
    rise_nxt = has_next && !nr_ge && (cfg_width != 16'd0);
  end

  // r is clamped to 0 once its rise is behind the word window
  always_comb begin
    pat = '0;
    for (int j = 0; j < NB; j++) begin
      if (21'(j) >= r && 21'(j) < f)
        pat[NB-1-j] = 1'b1;
      if (has_next && 21'(j) >= nr && 21'(j) < nf)
        pat[NB-1-j] = 1'b1;
    end
  end

  always_ff @(posedge CLK40) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    step     = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (st_v) begin
          if (rej) begin
            err_nx = 1'b1;
          end else if (bus.EN) begin
            ld       = 1'b1;
            state_nx = RUN;
          end
        end
      end
      RUN: begin
        if (!bus.EN) begin
          state_nx = IDLE;
        end else begin
          step = 1'b1;
          if (fin) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // the last word's edge already frees the channel for a new START
  assign accept = bus.START && bus.EN && !st_v &&
                  (state == IDLE || (step && fin));

  always_ff @(posedge CLK40) begin
    if (RST) begin
      st_v       <= 1'b0;
      cfg_delay  <= '0;
      cfg_width  <= '0;
      cfg_period <= '0;
      cfg_repeat <= '0;
      r          <= '0;
      f          <= '0;
      nr         <= '0;
      rpend      <= 1'b0;
      left       <= '0;
      out_q      <= '0;
      tx_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      st_v   <= accept;
      done_q <= done_nx;
      err_q  <= err_nx;
      out_q  <= {NB{bus.EN_INVERT}};
      if (accept) begin
        cfg_delay  <= bus.DELAY;
        cfg_width  <= bus.WIDTH;
        cfg_period <= bus.PERIOD;
        cfg_repeat <= bus.REPEAT;
      end
      if (ld) begin
        r     <= {5'd0, cfg_delay};
        f     <= {5'd0, cfg_delay} + {5'd0, cfg_width};
        nr    <= {5'd0, cfg_delay} + per16;
        rpend <= 1'b1;
        left  <= cfg_repeat;
      end
      if (step) begin
        out_q <= pat ^ {NB{bus.EN_INVERT}};
        if (rise_cur || rise_nxt)
          tx_q <= {bus.TIME_STAMP,
                   rise_cur ? r[3:0] : nr[3:0]};
        if (cur_done) begin
          r     <= nr_ge ? nr - 21'(NB) : '0;
          rpend <= nr_ge;
          f     <= nf - 21'(NB);
          nr    <= nr + per16 - 21'(NB);
          left  <= left - 8'd1;
        end else begin
          r     <= r_lt ? '0 : r - 21'(NB);
          rpend <= rpend && !r_lt;
          f     <= f - 21'(NB);
          nr    <= nr - 21'(NB);
        end
      end
    end
  end

  assign bus.OUT       = out_q;
  assign bus.BUSY      = (state == RUN);
  assign bus.DONE      = done_q;
  assign bus.ERROR     = err_q;
  assign bus.TX_RISING = tx_q;

endmodule

// File: tb/tb_tlu_ch_tx.sv
// tb_tlu_ch_tx: directed and random pulse trains against a
// fine-time reference model of the channel.
module tb_tlu_ch_tx;

  logic CLK40 = 1'b0;
  logic RST;
  logic [11:0] ts;

  tlu_ch_tx_if bus ();

  tlu_ch_tx #(.CLKDV(4)) dut (
    .CLK40 (CLK40),
    .RST   (RST),
    .bus   (bus.slave)
  );

  always #5 CLK40 = ~CLK40;

  always @(negedge CLK40) begin
    if (RST) ts <= '0;
    else     ts <= ts + 12'd1;
  end

  assign bus.TIME_STAMP = ts;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_w   [0:255];
  int          exp_pos [0:255];
  logic [15:0] exp_tx;

  task automatic tick;
    @(posedge CLK40);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // word k covers fine times 16k..16k+15, bit 15 first
  task automatic model(input int d, input int w, input int p,
                       input int rp, output int kl);
    int rl;
    rl = d + 16 * (rp - 1) * p;
    kl = (w > 0) ? (rl + w - 1) / 16 : rl / 16;
    for (int k = 0; k <= kl; k++) begin
      logic [15:0] wd;
      wd = '0;
      exp_pos[k] = -1;
      for (int j = 0; j < 16; j++) begin
        int t;
        t = 16 * k + j;
        for (int n = 0; n < rp; n++) begin
          int rn;
          rn = d + 16 * n * p;
          if (t >= rn && t < rn + w) wd[15-j] = 1'b1;
          if (w > 0 && t == rn) exp_pos[k] = j;
        end
      end
      exp_w[k] = wd;
    end
  endtask

  task automatic run_train(input int d, input int w,
                           input int p, input int rp,
                           input bit inv, input int poke,
                           input int abort_k, input int rst_k);
    int kl;
    logic [15:0] idle;
    idle = {16{inv}};
    model(d, w, p, rp, kl);
    bus.EN        = 1'b1;
    bus.EN_INVERT = inv;
    bus.DELAY     = 16'(d);
    bus.WIDTH     = 16'(w);
    bus.PERIOD    = 16'(p);
    bus.REPEAT    = 8'(rp);
    bus.START     = 1'b1;
    tick;
    bus.START = 1'b0;
    chk("busy_c0", bus.BUSY, 0);
    chk("err_c0", bus.ERROR, 0);
    tick;
    chk("busy_c1", bus.BUSY, 1);
    chk("err_c1", bus.ERROR, 0);
    chk("out_c1", bus.OUT, idle);
    for (int k = 0; k <= kl; k++) begin
      tick;
      bus.START = 1'b0;
      chk($sformatf("word%0d", k), bus.OUT, exp_w[k] ^ idle);
      if (exp_pos[k] >= 0)
        exp_tx = {bus.TIME_STAMP, 4'(exp_pos[k])};
      chk($sformatf("txr%0d", k), bus.TX_RISING, exp_tx);
      chk($sformatf("busy%0d", k), bus.BUSY, (k < kl));
      chk($sformatf("done%0d", k), bus.DONE, (k == kl));
      chk($sformatf("err%0d", k), bus.ERROR, 0);
      if (k == abort_k) begin
        bus.EN = 1'b0;
        tick;
        chk("abort_out", bus.OUT, idle);
        chk("abort_busy", bus.BUSY, 0);
        chk("abort_done", bus.DONE, 0);
        tick;
        chk("abort_done2", bus.DONE, 0);
        chk("abort_busy2", bus.BUSY, 0);
        bus.EN = 1'b1;
        tick;
        return;
      end
      if (k == rst_k) begin
        RST = 1'b1;
        tick;
        exp_tx = '0;
        chk("rst_out", bus.OUT, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_done", bus.DONE, 0);
        chk("rst_err", bus.ERROR, 0);
        chk("rst_txr", bus.TX_RISING, exp_tx);
        RST = 1'b0;
        tick;
        chk("rst_idle", bus.OUT, idle);
        return;
      end
      if (k == poke) begin
        bus.START  = 1'b1;
        bus.DELAY  = 16'hFFFF;
        bus.REPEAT = 8'd0;
      end
    end
    tick;
    chk("end_done", bus.DONE, 0);
    chk("end_busy", bus.BUSY, 0);
    chk("end_out", bus.OUT, idle);
    chk("end_err", bus.ERROR, 0);
  endtask

  task automatic reject(input int d, input int w,
                        input int p, input int rp);
    bus.EN     = 1'b1;
    bus.DELAY  = 16'(d);
    bus.WIDTH  = 16'(w);
    bus.PERIOD = 16'(p);
    bus.REPEAT = 8'(rp);
    bus.START  = 1'b1;
    tick;
    bus.START = 1'b0;
    chk("rej_err0", bus.ERROR, 0);
    tick;
    chk("rej_err1", bus.ERROR, 1);
    chk("rej_busy1", bus.BUSY, 0);
    chk("rej_out1", bus.OUT, {16{bus.EN_INVERT}});
    tick;
    chk("rej_err2", bus.ERROR, 0);
    chk("rej_busy2", bus.BUSY, 0);
    chk("rej_out2", bus.OUT, {16{bus.EN_INVERT}});
  endtask

  initial begin
    RST           = 1'b1;
    bus.EN        = 1'b0;
    bus.EN_INVERT = 1'b0;
    bus.START     = 1'b0;
    bus.DELAY     = '0;
    bus.WIDTH     = '0;
    bus.PERIOD    = '0;
    bus.REPEAT    = '0;
    exp_tx        = '0;
    tick;
    tick;
    tick;
    chk("rst_out", bus.OUT, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_done", bus.DONE, 0);
    chk("rst_err", bus.ERROR, 0);
    chk("rst_txr", bus.TX_RISING, 0);
    RST = 1'b0;
    tick;
    tick;

    run_train(16'h25, 16'h13, 1, 1, 1'b0, -1, -1, -1);
    run_train(16'h10, 16'h10, 1, 1, 1'b0, -1, -1, -1);
    run_train(16'h0F, 1, 1, 1, 1'b0, -1, -1, -1);
    run_train(0, 16, 4, 3, 1'b0, 2, -1, -1);
    tick;
    chk("post_poke_busy", bus.BUSY, 0);
    chk("post_poke_err", bus.ERROR, 0);

    reject(0, 16, 1, 2);
    reject(5, 3, 2, 0);

    bus.EN    = 1'b0;
    bus.START = 1'b1;
    bus.REPEAT = 8'd0;
    tick;
    bus.START = 1'b0;
    tick;
    chk("en0_err", bus.ERROR, 0);
    chk("en0_busy", bus.BUSY, 0);
    tick;
    chk("en0_busy2", bus.BUSY, 0);
    chk("en0_out", bus.OUT, 0);

    bus.EN        = 1'b1;
    bus.EN_INVERT = 1'b1;
    tick;
    chk("inv_idle", bus.OUT, 16'hFFFF);
    run_train(4, 8, 1, 1, 1'b1, -1, -1, -1);
    bus.EN_INVERT = 1'b0;
    tick;

    run_train(20, 0, 3, 2, 1'b0, -1, -1, -1);
    run_train(0, 256, 1, 1, 1'b0, -1, 3, -1);
    run_train(3, 40, 1, 1, 1'b1, -1, -1, 2);
    run_train(9, 21, 2, 3, 1'b0, -1, -1, -1);

    for (int i = 0; i < 10; i++) begin
      int rp, p, w, d;
      bit inv;
      rp  = $urandom_range(1, 4);
      p   = $urandom_range(1, 8);
      w   = (rp > 1) ? $urandom_range(0, 16 * p - 1)
                     : $urandom_range(0, 60);
      d   = $urandom_range(0, 80);
      inv = 1'($urandom_range(0, 1));
      run_train(d, w, p, rp, inv, -1, -1, -1);
    end

    for (int i = 0; i < 3; i++) begin
      int p;
      p = $urandom_range(1, 4);
      reject($urandom_range(0, 50), $urandom_range(16 * p, 16 * p + 40),
             p, $urandom_range(2, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
